// File: rtl/sd_spi_sequencer_if.sv
// Request/response and SPI pin bundle for the SD-card byte sequencer.
// The host side drives requests and the card's MISO line; the sequencer
// side returns the received byte, status flags and the SPI clock/MOSI.
interface sd_spi_sequencer_if;
  logic       start;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       ovr_clr;
  logic       sdclk;
  logic       sddo;
  logic       sddi;

  modport master (
    output start, din, ovr_clr, sddi,
    input  dout, busy, done, overrun, sdclk, sddo
  );

  modport slave (
    input  start, din, ovr_clr, sddi,
    output dout, busy, done, overrun, sdclk, sddo
  );
endinterface

// File: rtl/sd_spi_sequencer.sv
// Byte-level SPI mode-0 master for the SD-card datapath (ports #57/#77).
// Shifts one byte out MSB first while capturing one byte in, and keeps a
// single pending request so back-to-back CPU accesses chain without a gap.
module sd_spi_sequencer #(
  parameter int DIV = 2
) (
  input logic               fclk,
  input logic               rst,
  sd_spi_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  state_t     state;
  logic [3:0] divcnt;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic [7:0] pend_data;
  logic       inbit;
  logic       pending;
  logic       phase_end;
  logic       ovr_set;

  assign phase_end = (divcnt == DIV_LAST);
  // A request arriving while one is already queued is the only drop case;
  // pending can only be set while the engine is active.
  assign ovr_set   = bus.start & pending;
  assign bus.busy  = (state != IDLE) | pending;

  // Transfer engine: phase timing, shifting, result capture and request queueing.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state     <= IDLE;
      bus.sdclk <= 1'b0;
      bus.sddo  <= 1'b1;
      bus.done  <= 1'b0;
      bus.dout  <= 8'hFF;
      pending   <= 1'b0;
      divcnt    <= 4'd0;
      bitcnt    <= 3'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg    <= bus.din;
            bus.sddo <= bus.din[7];
            bitcnt   <= 3'd0;
            divcnt   <= 4'd0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (bus.start && !pending) begin
            pending   <= 1'b1;
            pend_data <= bus.din;
          end
          if (phase_end) begin
            divcnt    <= 4'd0;
            bus.sdclk <= 1'b1;
            inbit     <= bus.sddi;
            state     <= HIGH;
          end else begin
            divcnt <= divcnt + 4'd1;
          end
        end
        HIGH: begin
          if (bus.start && !pending) begin
            pending   <= 1'b1;
            pend_data <= bus.din;
          end
          if (phase_end) begin
            divcnt    <= 4'd0;
            bus.sdclk <= 1'b0;
            shreg     <= {shreg[6:0], inbit};
            if (bitcnt == 3'd7) begin
              // Result and done go out together so the FIN cycle shows both.
              bus.dout <= {shreg[6:0], inbit};
              bus.done <= 1'b1;
              bus.sddo <= 1'b1;
              state    <= FIN;
            end else begin
              bus.sddo <= shreg[6];
              bitcnt   <= bitcnt + 3'd1;
              state    <= LOW;
            end
          end else begin
            divcnt <= divcnt + 4'd1;
          end
        end
        FIN: begin
          // A queued request (or one arriving right now) launches with no idle gap.
          bitcnt <= 3'd0;
          divcnt <= 4'd0;
          if (pending) begin
            pending  <= 1'b0;
            shreg    <= pend_data;
            bus.sddo <= pend_data[7];
            state    <= LOW;
          end else if (bus.start) begin
            shreg    <= bus.din;
            bus.sddo <= bus.din[7];
            state    <= LOW;
          end else begin
            bus.sddo <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge fclk) begin
    if (rst) begin
      bus.overrun <= 1'b0;
    end else begin
      bus.overrun <= ovr_set | (bus.overrun & ~bus.ovr_clr);
    end
  end

endmodule

// File: tb/tb_sd_spi_sequencer.sv
// Bench for sd_spi_sequencer: a DIV=2 and a DIV=1 instance, each with a
// mode-0 SPI slave model and a scoreboard of expected (mosi, miso, due cycle).
module tb_sd_spi_sequencer;
  logic fclk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  sd_spi_sequencer_if a_if();
  sd_spi_sequencer_if b_if();

  sd_spi_sequencer #(.DIV(2)) dut_a (.fclk(fclk), .rst(rst), .bus(a_if.slave));
  sd_spi_sequencer #(.DIV(1)) dut_b (.fclk(fclk), .rst(rst), .bus(b_if.slave));

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] miso;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model and output monitor for the DIV=2 instance
  logic       pa_sclk = 1'b0;
  int         ra = 0, hia = 0;
  logic [7:0] moa = 8'h00;
  logic       bada = 1'b0, sd0a = 1'b0, gapa = 1'b0;

  always @(negedge fclk) begin
    if (!rst) begin
      if (a_if.sdclk) hia++;
      if (a_if.sdclk && !pa_sclk) begin
        moa = {moa[6:0], a_if.sddo};
        ra++;
      end
      if (!a_if.sdclk && pa_sclk) begin
        if (hia != 2) bada = 1'b1;
        hia = 0;
      end
      if (!a_if.sddo) sd0a = 1'b1;
      if (qa.size() != 0 && !a_if.busy) gapa = 1'b1;
      if (a_if.done) begin
        check("a_done_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("a_dout", 32'(a_if.dout), 32'(ea.miso));
          check("a_mosi", 32'(moa), 32'(ea.mosi));
          check("a_done_cycle", 32'(cyc), 32'(ea.due));
          check("a_sdclk_pulses", 32'(ra), 32'd8);
          check("a_high_width", 32'(bada), 32'd0);
        end
        ra = 0;
        bada = 1'b0;
      end
      pa_sclk = a_if.sdclk;
    end
    a_if.sddi = (qa.size() != 0 && ra < 8) ? qa[0].miso[7 - ra] : 1'b1;
  end

  // Slave model and output monitor for the DIV=1 instance
  logic       pb_sclk = 1'b0;
  int         rb = 0, hib = 0;
  logic [7:0] mob = 8'h00;
  logic       badb = 1'b0;

  always @(negedge fclk) begin
    if (!rst) begin
      if (b_if.sdclk) hib++;
      if (b_if.sdclk && !pb_sclk) begin
        mob = {mob[6:0], b_if.sddo};
        rb++;
      end
      if (!b_if.sdclk && pb_sclk) begin
        if (hib != 1) badb = 1'b1;
        hib = 0;
      end
      if (b_if.done) begin
        check("b_done_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("b_dout", 32'(b_if.dout), 32'(eb.miso));
          check("b_mosi", 32'(mob), 32'(eb.mosi));
          check("b_done_cycle", 32'(cyc), 32'(eb.due));
          check("b_sdclk_pulses", 32'(rb), 32'd8);
          check("b_high_width", 32'(badb), 32'd0);
        end
        rb = 0;
        badb = 1'b0;
      end
      pb_sclk = b_if.sdclk;
    end
    b_if.sddi = (qb.size() != 0 && rb < 8) ? qb[0].miso[7 - rb] : 1'b1;
  end

  // One-cycle start on the DIV=2 instance; prev_due < 0 means launched from idle.
  task automatic launch_a(input logic [7:0] d, input logic [7:0] slv,
                          input int prev_due, output int due);
    exp_t e;
    a_if.start = 1'b1;
    a_if.din   = d;
    @(posedge fclk); #1;
    a_if.start = 1'b0;
    a_if.din   = 8'h00;
    due = (prev_due < 0) ? cyc + 32 : prev_due + 33;
    e.mosi = d; e.miso = slv; e.due = due;
    qa.push_back(e);
  endtask

  task automatic wait_idle(input bit b, input int lim);
    int n = 0;
    while (((b ? b_if.busy : a_if.busy) || (b ? qb.size() : qa.size()) != 0) && n < lim) begin
      @(posedge fclk); #1;
      n++;
    end
    check(b ? "b_idle_in_time" : "a_idle_in_time", 32'(n < lim), 32'd1);
  endtask

  initial begin
    int d1, d2, n;
    exp_t e;
    rst = 1'b1;
    a_if.start = 1'b0; a_if.din = 8'h00; a_if.ovr_clr = 1'b0;
    b_if.start = 1'b0; b_if.din = 8'h00; b_if.ovr_clr = 1'b0;
    repeat (3) @(posedge fclk);
    #1 rst = 1'b0;
    check("rst_sdclk", 32'(a_if.sdclk), 32'd0);
    check("rst_sddo", 32'(a_if.sddo), 32'd1);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_overrun", 32'(a_if.overrun), 32'd0);
    check("rst_dout", 32'(a_if.dout), 32'hFF);

    // Basic byte: A5 out, 3C back
    launch_a(8'hA5, 8'h3C, -1, d1);
    check("busy_during", 32'(a_if.busy), 32'd1);
    wait_idle(1'b0, 100);
    check("busy_after", 32'(a_if.busy), 32'd0);

    // All-ones read: MOSI must never drop
    @(posedge fclk); #1;
    sd0a = 1'b0;
    launch_a(8'hFF, 8'hFF, -1, d1);
    wait_idle(1'b0, 100);
    check("ff_sddo_const", 32'(sd0a), 32'd0);

    // Second request mid-transfer chains with no idle gap
    gapa = 1'b0;
    launch_a(8'h9C, 8'hC3, -1, d1);
    repeat (9) @(posedge fclk);
    #1;
    launch_a(8'h12, 8'h47, d1, d2);
    wait_idle(1'b0, 200);
    check("pend_busy_no_gap", 32'(gapa), 32'd0);

    // Three starts back to back: third dropped; clear in the drop cycle loses
    gapa = 1'b0;
    a_if.start = 1'b1; a_if.din = 8'h11;
    @(posedge fclk); #1;
    e.mosi = 8'h11; e.miso = 8'h88; e.due = cyc + 32; qa.push_back(e);
    d1 = e.due;
    a_if.din = 8'h22;
    @(posedge fclk); #1;
    e.mosi = 8'h22; e.miso = 8'h44; e.due = d1 + 33; qa.push_back(e);
    a_if.din = 8'h33; a_if.ovr_clr = 1'b1;
    @(posedge fclk); #1;
    a_if.start = 1'b0; a_if.din = 8'h00; a_if.ovr_clr = 1'b0;
    check("overrun_set_wins", 32'(a_if.overrun), 32'd1);
    wait_idle(1'b0, 200);
    check("overrun_sticky", 32'(a_if.overrun), 32'd1);
    check("ovr_busy_no_gap", 32'(gapa), 32'd0);
    a_if.ovr_clr = 1'b1;
    @(posedge fclk); #1;
    a_if.ovr_clr = 1'b0;
    check("overrun_cleared", 32'(a_if.overrun), 32'd0);

    // Reset during bit 4, then a clean transfer
    launch_a(8'h5A, 8'hA5, -1, d1);
    n = 0;
    while (ra < 4 && n < 100) begin @(posedge fclk); #1; n++; end
    check("a_bit4_reached", 32'(ra >= 4), 32'd1);
    rst = 1'b1;
    @(posedge fclk); #1;
    rst = 1'b0;
    qa.delete(); ra = 0; hia = 0; bada = 1'b0; pa_sclk = 1'b0;
    check("midrst_sdclk", 32'(a_if.sdclk), 32'd0);
    check("midrst_sddo", 32'(a_if.sddo), 32'd1);
    check("midrst_busy", 32'(a_if.busy), 32'd0);
    check("midrst_dout", 32'(a_if.dout), 32'hFF);
    check("midrst_done", 32'(a_if.done), 32'd0);
    launch_a(8'hC6, 8'h6C, -1, d1);
    wait_idle(1'b0, 100);

    // DIV=1 instance: 81 out, 7E back, sdclk toggling every cycle
    b_if.start = 1'b1; b_if.din = 8'h81;
    @(posedge fclk); #1;
    b_if.start = 1'b0; b_if.din = 8'h00;
    e.mosi = 8'h81; e.miso = 8'h7E; e.due = cyc + 16; qb.push_back(e);
    check("b_busy_during", 32'(b_if.busy), 32'd1);
    wait_idle(1'b1, 60);
    check("b_busy_after", 32'(b_if.busy), 32'd0);

    repeat (2) @(posedge fclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
